// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg: shared state codes and default geometry for the FFT frame sequencer
package fft_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STREAM = 3'd1,
    DRAIN  = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } seqState_e;
  localparam int N_SAMPLES_DEF = 128;
  localparam int SAMPLE_W_DEF  = 16;
  localparam int CE_DIV_DEF    = 4;
  localparam int TIMEOUT_DEF   = 4096;
endpackage

// File: rtl/ce_pacer.sv
// ce_pacer: modulo-CE_DIV counter flagging the CE cycle and the cycle before it
module ce_pacer
  import fft_ctrl_pkg::*;
#(
  parameter int CE_DIV = CE_DIV_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic ce_pulse,
  output logic pre_pulse
);
  localparam int CW = $clog2(CE_DIV);
  logic [CW-1:0] count;
  assign ce_pulse  = count == CW'(CE_DIV - 1);
  assign pre_pulse = count == CW'(CE_DIV - 2);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count <= '0;
    else if (clear) count <= '0;
    else if (enable) count <= ce_pulse ? '0 : count + 1'b1;
endmodule

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: buffers one MCU-written frame and streams it into the FFT with paced CE pulses
module fft_frame_sequencer
  import fft_ctrl_pkg::*;
#(
  parameter int N_SAMPLES = N_SAMPLES_DEF,
  parameter int SAMPLE_W  = SAMPLE_W_DEF,
  parameter int CE_DIV    = CE_DIV_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wr_valid,
  input  logic [$clog2(N_SAMPLES)-1:0] wr_idx,
  input  logic [SAMPLE_W-1:0]          wr_data,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         fft_sync,
  input  logic                         td_done,
  output logic                         fft_ce,
  output logic [SAMPLE_W-1:0]          fft_sample,
  output logic                         td_enable,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         error,
  output logic [$clog2(N_SAMPLES)-1:0] next_idx,
  output logic [2:0]                   state
);
  localparam int IW = $clog2(N_SAMPLES);
  localparam int TW = $clog2(TIMEOUT + 1);
  seqState_e curState, nextState;
  logic [SAMPLE_W-1:0] sampleBuf [N_SAMPLES];
  logic [SAMPLE_W-1:0] rdData;
  logic [IW-1:0] nextIdx, rdPtr;
  logic [TW-1:0] drainCnt;
  logic bufFull, wrOk, cePulse, prePulse, paceEn, paceClr;
  assign wrOk       = wr_valid && curState == IDLE && !bufFull && wr_idx == nextIdx;
  assign paceEn     = nextState == STREAM || nextState == DRAIN;
  assign paceClr    = nextState == IDLE;
  assign busy       = curState == STREAM || curState == DRAIN;
  assign error      = curState == ERR;
  assign next_idx   = nextIdx;
  assign state      = curState;
  ce_pacer #(.CE_DIV(CE_DIV)) u_pacer (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (paceEn),
    .clear    (paceClr),
    .ce_pulse (cePulse),
    .pre_pulse(prePulse)
  );
  always_comb begin
    nextState = curState;
    case (curState)
      IDLE:    nextState = (wr_valid && !wrOk) ? ERR : (start && bufFull) ? STREAM : IDLE;
      STREAM:  nextState = wr_valid ? ERR : (fft_ce && rdPtr == '0) ? DRAIN : STREAM;
      DRAIN:   nextState = wr_valid ? ERR : td_done ? DONE :
                           (fft_ce && drainCnt == TW'(TIMEOUT - 1)) ? ERR : DRAIN;
      DONE:    nextState = wr_valid ? ERR : IDLE;
      ERR:     nextState = ERR;
      default: nextState = IDLE;
    endcase
    if (abort) nextState = IDLE;
  end
  // The read port is also primed while idle so the first sample is ready for any CE_DIV.
  always_ff @(posedge clk) begin
    if (wrOk) sampleBuf[wr_idx] <= wr_data;
    if (prePulse || curState == IDLE) rdData <= sampleBuf[rdPtr];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      curState   <= IDLE;
      nextIdx    <= '0;
      bufFull    <= 1'b0;
      rdPtr      <= '0;
      drainCnt   <= '0;
      fft_ce     <= 1'b0;
      fft_sample <= '0;
      td_enable  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      curState   <= nextState;
      fft_ce     <= cePulse && paceEn;
      frame_done <= curState == DONE;
      td_enable  <= nextState == DRAIN && (td_enable || (curState == DRAIN && fft_ce && fft_sync));
      if (cePulse && paceEn) fft_sample <= curState == STREAM ? rdData : '0;
      if (abort || curState == DONE) begin
        nextIdx  <= '0;
        bufFull  <= 1'b0;
        rdPtr    <= '0;
        drainCnt <= '0;
      end else begin
        if (wrOk && nextIdx == IW'(N_SAMPLES - 1)) bufFull <= 1'b1;
        else if (wrOk) nextIdx <= nextIdx + 1'b1;
        if (cePulse && curState == STREAM && paceEn) rdPtr <= rdPtr + 1'b1;
        if (fft_ce && curState == DRAIN) drainCnt <= drainCnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: random-frame bench timing every CE, sample and handshake from frame arithmetic
module tb_fft_frame_sequencer;
  localparam int N = 128;
  localparam int SW = 16;
  localparam int DIV = 4;
  localparam int TMO = 16;
  localparam int LAST = N * DIV;
  logic clk, reset_n, wr_valid, start, abort, fft_sync, td_done;
  logic [6:0] wr_idx, next_idx;
  logic [SW-1:0] wr_data, fft_sample;
  logic fft_ce, td_enable, busy, frame_done, error;
  logic [2:0] state;
  logic [SW-1:0] frameData [N];
  int nChecks = 0;
  int nErrors = 0;

  fft_frame_sequencer #(.N_SAMPLES(N), .SAMPLE_W(SW), .CE_DIV(DIV), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_idx(wr_idx), .wr_data(wr_data),
    .start(start), .abort(abort), .fft_sync(fft_sync), .td_done(td_done),
    .fft_ce(fft_ce), .fft_sample(fft_sample), .td_enable(td_enable), .busy(busy),
    .frame_done(frame_done), .error(error), .next_idx(next_idx), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkEq({tag, "_ce"}, fft_ce, 0);
    checkEq({tag, "_sample"}, fft_sample, 0);
    checkEq({tag, "_td_enable"}, td_enable, 0);
    checkEq({tag, "_busy"}, busy, 0);
    checkEq({tag, "_frame_done"}, frame_done, 0);
    checkEq({tag, "_error"}, error, 0);
    checkEq({tag, "_next_idx"}, next_idx, 0);
    checkEq({tag, "_state"}, state, 0);
  endtask

  task automatic randomData();
    for (int i = 0; i < N; i++) frameData[i] = SW'($urandom);
  endtask

  task automatic fillFrame(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_valid = 1'b1;
      wr_idx = 7'(i);
      wr_data = frameData[i];
    end
    @(negedge clk);
    wr_valid = 1'b0;
    checkEq("fill_next_idx", next_idx, n == N ? N - 1 : n);
    checkEq("fill_state", state, 0);
  endtask

  task automatic writeOne(input int idx, input logic [SW-1:0] d);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_idx = 7'(idx);
    wr_data = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic pulseAbort();
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkEq("abort_state", state, 0);
    checkEq("abort_next_idx", next_idx, 0);
    checkEq("abort_error", error, 0);
    checkEq("abort_td_enable", td_enable, 0);
  endtask

  // start is high in cycle T; iteration k observes cycle T+k
  task automatic startAndStream(input int stopAt);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkEq("stream_entry", state, 1);
    for (int k = 1; k <= stopAt; k++) begin
      if (k > 1) @(negedge clk);
      checkEq("stream_ce", fft_ce, k % DIV == 0);
      checkEq("stream_busy", busy, 1);
      if (k % DIV == 0) checkEq("stream_sample", fft_sample, frameData[k / DIV - 1]);
    end
  endtask

  task automatic drainDone(input int syncCe, input int delay);
    int ks, kd;
    ks = LAST + DIV * syncCe;
    kd = ks + delay;
    for (int k = LAST + 1; k <= kd + 2; k++) begin
      @(negedge clk);
      if (k == LAST + 1) checkEq("drain_entry", state, 2);
      if (k <= kd) begin
        checkEq("drain_ce", fft_ce, k % DIV == 0);
        if (k % DIV == 0) checkEq("drain_sample", fft_sample, 0);
        checkEq("drain_td_enable", td_enable, k > ks);
        checkEq("drain_busy", busy, 1);
      end
      fft_sync = k == ks;
      td_done = k == kd;
      if (k == kd + 1) begin
        checkEq("done_state", state, 3);
        checkEq("done_early", frame_done, 0);
      end
      if (k == kd + 2) begin
        checkEq("frame_done", frame_done, 1);
        checkEq("done_idle", state, 0);
        checkEq("done_next_idx", next_idx, 0);
        checkEq("done_busy", busy, 0);
      end
    end
    @(negedge clk);
    checkEq("frame_done_once", frame_done, 0);
  endtask

  task automatic drainTimeout();
    for (int k = LAST + 1; k <= LAST + DIV * TMO + 20; k++) begin
      @(negedge clk);
      if (k <= LAST + DIV * TMO) begin
        checkEq("to_ce", fft_ce, k % DIV == 0);
        checkEq("to_drain", state, 2);
      end else begin
        checkEq("to_ce_off", fft_ce, 0);
        checkEq("to_state", state, 4);
        checkEq("to_error", error, 1);
        checkEq("to_busy", busy, 0);
      end
    end
  endtask

  initial begin
    reset_n = 1'b1;
    {wr_valid, start, abort, fft_sync, td_done} = '0;
    wr_idx = '0;
    wr_data = '0;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkIdleOutputs("reset");
    reset_n = 1'b1;
    @(negedge clk);
    checkIdleOutputs("post_reset");

    for (int i = 0; i < N; i++) frameData[i] = SW'(i * 3);
    fillFrame(N);
    startAndStream(LAST);
    drainDone(10, 20);

    writeOne(0, 16'h1111);
    writeOne(1, 16'h2222);
    writeOne(3, 16'h4444);
    checkEq("skip_error", error, 1);
    checkEq("skip_state", state, 4);
    pulseAbort();

    randomData();
    fillFrame(N - 1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkEq("start_not_full", state, 0);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_idx = 7'(N - 1);
    wr_data = frameData[N - 1];
    start = 1'b1;
    @(negedge clk);
    {wr_valid, start} = '0;
    checkEq("start_with_last_write", state, 0);
    checkEq("full_next_idx", next_idx, N - 1);
    startAndStream(LAST);
    drainTimeout();
    pulseAbort();

    for (int f = 0; f < 2; f++) begin
      randomData();
      fillFrame(N);
      startAndStream(LAST);
      drainDone(int'($urandom_range(1, 8)), int'($urandom_range(1, 20)));
    end

    randomData();
    fillFrame(N);
    startAndStream(100);
    @(negedge clk);
    reset_n = 1'b0;
    #1 checkIdleOutputs("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    randomData();
    fillFrame(N);
    startAndStream(LAST);
    drainDone(int'($urandom_range(1, 8)), int'($urandom_range(1, 20)));

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule

// File: doc/fft_frame_sequencer.md
# fft_frame_sequencer

Sequences one 128-point FFT frame: buffers MCU-supplied samples written in order, then streams them into the FFT core with paced single-cycle chip-enable pulses. It keeps pacing through the output phase and arms the tone detector on the FFT's sync. It reports completion or error back to the I2C-facing status registers. Sits between the I2C register bank and the FFT/tone-detector pair, replacing ad-hoc sequencing in the top-level control block.

## Interface
- N_SAMPLES, 128: frame length; power of two.
- SAMPLE_W, 16: sample width.
- CE_DIV, 4: clocks per CE period; must be ≥2.
- TIMEOUT, 4096: maximum CE pulses in DRAIN before error.
- clk  in  1  single clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  sample write strobe (one cycle per sample).
- wr_idx  in  7  index of written sample.
- wr_data  in  SAMPLE_W  sample value.
- start  in  1  begin streaming (level sampled each clock).
- abort  in  1  return to IDLE from any state.
- fft_sync  in  1  FFT first-output-bin marker; sampled only on CE cycles.
- td_done  in  1  tone detector finished.
- fft_ce  out  1  one-cycle chip-enable pulse to FFT and tone detector.
- fft_sample  out  SAMPLE_W  sample presented to FFT.
- td_enable  out  1  tone detector enable.
- busy  out  1  high in STREAM and DRAIN.
- frame_done  out  1  one-cycle pulse on frame completion.
- error  out  1  high while in ERR.
- next_idx  out  7  index of the next sample expected from the MCU.
- state  out  3  current state code, for debug status.

## Operation
- States: IDLE(0), STREAM(1), DRAIN(2), DONE(3), ERR(4).
- IDLE: a write with wr_idx==next_idx stores into the buffer and increments the fill count. A write with any other index goes to ERR. When the fill count reaches N_SAMPLES, the buffer is full and further writes go to ERR. start with the buffer full goes to STREAM; start with it not full is ignored.
- STREAM: pacer counts 0..CE_DIV-1; fft_ce pulses when the count is CE_DIV-1. Each pulse presents buffer[rd_ptr], then rd_ptr increments. After the N_SAMPLES-th pulse, go to DRAIN.
- DRAIN: pacing continues with fft_sample=0. On the first CE cycle with fft_sync=1, set td_enable=1; it stays high until leaving DRAIN. td_done=1 goes to DONE. TIMEOUT pulses without td_done goes to ERR.
- DONE: frame_done=1 for one cycle. Clear fill count, next_idx and rd_ptr, then go to IDLE.
- ERR: hold all counters and drive fft_ce=0. Leave only on abort.
- Any wr_valid outside IDLE goes to ERR.
- abort in any state goes to IDLE and clears counters, td_enable and pacer. abort beats start, a write and td_done in the same cycle.
- Reset values: fft_ce=0, fft_sample=0, td_enable=0, busy=0, frame_done=0, error=0, next_idx=0, state=IDLE.

## Timing
- All outputs are registered.
- start accepted at cycle T (STREAM entered at T+1): first fft_ce at T+CE_DIV, then every CE_DIV cycles.
- fft_sample is valid on the fft_ce cycle and is held until the next pulse.
- Buffer read is registered: the address is issued on the cycle the pacer equals CE_DIV-2.
- The last sample pulse occurs at T+N_SAMPLES·CE_DIV. DRAIN is entered on the next cycle, and the pacer continues without phase reset.
- td_done seen at cycle D: frame_done=1 at D+2, IDLE at D+2.
- A write at index N_SAMPLES-1 and start in the same cycle: start is ignored because the buffer is not yet full.
- next_idx wraps from N_SAMPLES-1 to 0 only via DONE or abort. A full buffer holds next_idx=N_SAMPLES-1 plus the full flag.
- Asynchronous reset mid-frame: all state is cleared immediately. Buffer contents are don't-care.

## Structure
- Package fft_ctrl_pkg: state enum codes, default N_SAMPLES/SAMPLE_W/CE_DIV constants.
- Sub-module ce_pacer: modulo-CE_DIV counter with enable and clear; outputs ce_pulse and pre_pulse (count==CE_DIV-2).
- Sample buffer: inferred N_SAMPLES×SAMPLE_W register array, one write port and one registered read port.

## Test plan
- Write idx 0..127 with data=idx·3, pulse start, CE_DIV=4: 128 fft_ce pulses 4 cycles apart with fft_sample=0,3,…,381; busy=1 throughout.
- Drive fft_sync on the 10th DRAIN CE, td_done 20 cycles later: td_enable rises after that CE; frame_done pulses once; state=0; next_idx=0.
- Write idx 0,1, then 3: error=1, state=4. Assert abort: state=0, next_idx=0, error=0.
- Fill 127 samples and pulse start: no transition; 128th write plus start, then a later start: STREAM.
- No td_done in DRAIN with TIMEOUT=16: ERR after the 16th DRAIN CE; fft_ce stays 0 afterwards.
- Drop reset_n mid-STREAM: all outputs are at reset values in the same cycle. After release, a fresh 128-sample frame completes normally.
